// File: rtl/core_rst_seq.sv
// Core-domain reset sequencer: releases staged resets once PLL lock has been stable,
// and on lock loss or lock timeout re-asserts everything and pulses the PLL request.
module core_rst_seq #(
    parameter int NUM_STAGES   = 3,
    parameter int LOCK_HOLD    = 1024,
    parameter int STAGE_GAP    = 16,
    parameter int STDY_PULSE   = 4,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int CNT_W        = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_pll_locked,
    output logic                  o_pll_stdy_rst,
    output logic [NUM_STAGES-1:0] o_rst_stage,
    output logic                  o_ready,
    output logic [CNT_W-1:0]      o_lock_loss_cnt,
    output logic [2:0]            o_state
);
    // One shared timer covers hold, timeout, stage gap and pulse width.
    localparam int T_MAX_A = (LOCK_TIMEOUT > LOCK_HOLD) ? LOCK_TIMEOUT : LOCK_HOLD;
    localparam int T_MAX_B = (STAGE_GAP > STDY_PULSE) ? STAGE_GAP : STDY_PULSE;
    localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int TW      = $clog2(T_MAX + 1);
    localparam int IW      = $clog2(NUM_STAGES + 1);

    localparam logic [TW-1:0]         TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0]         HOLD_LAST    = TW'(LOCK_HOLD - 1);
    localparam logic [TW-1:0]         GAP_LAST     = TW'(STAGE_GAP - 1);
    localparam logic [TW-1:0]         PULSE_LAST   = TW'(STDY_PULSE - 1);
    localparam logic [IW-1:0]         IDX_DONE     = IW'(NUM_STAGES);
    localparam logic [NUM_STAGES-1:0] STAGE_ONE    = NUM_STAGES'(1);

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        HOLD      = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        PULSE     = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [TW-1:0]           tmr_q, tmr_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [NUM_STAGES-1:0]   stage_d;
    logic                    ready_d;
    logic                    stdy_d;
    logic [CNT_W-1:0]        loss_d;
    logic [1:0]              sync_q;
    logic                    lk;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) sync_q <= '0;
        else       sync_q <= {sync_q[0], i_pll_locked};
    end

    assign lk = sync_q[1];

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch can be inferred.
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        stage_d = o_rst_stage;
        ready_d = o_ready;
        stdy_d  = 1'b0;
        loss_d  = o_lock_loss_cnt;

        if ((state_q == RELEASE || state_q == RUN) && !lk) begin
            // Lock loss wins over any release step, including the RUN entry.
            state_d = PULSE;
            tmr_d   = '0;
            stage_d = '1;
            ready_d = 1'b0;
            stdy_d  = 1'b1;
            loss_d  = (&o_lock_loss_cnt) ? o_lock_loss_cnt : o_lock_loss_cnt + 1'b1;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    stage_d = '1;
                    ready_d = 1'b0;
                    if (lk) begin
                        state_d = HOLD;
                        tmr_d   = '0;
                    end else if (tmr_q == TIMEOUT_LAST) begin
                        state_d = PULSE;
                        tmr_d   = '0;
                        stdy_d  = 1'b1;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (!lk) begin
                        state_d = WAIT_LOCK;
                        tmr_d   = '0;
                    end else if (tmr_q == HOLD_LAST) begin
                        state_d = RELEASE;
                        tmr_d   = '0;
                        idx_d   = '0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                RELEASE: begin
                    // Timer counts down between steps; a zero timer releases the next stage.
                    if (tmr_q != '0) begin
                        tmr_d = tmr_q - 1'b1;
                    end else if (idx_q == IDX_DONE) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        stage_d = o_rst_stage & ~(STAGE_ONE << idx_q);
                        idx_d   = idx_q + 1'b1;
                        tmr_d   = GAP_LAST;
                    end
                end
                RUN: begin
                    stage_d = '0;
                    ready_d = 1'b1;
                end
                PULSE: begin
                    stdy_d = 1'b1;
                    if (tmr_q == PULSE_LAST) begin
                        state_d = WAIT_LOCK;
                        tmr_d   = '0;
                        stdy_d  = 1'b0;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_d = WAIT_LOCK;
                    tmr_d   = '0;
                    stage_d = '1;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q         <= WAIT_LOCK;
            tmr_q           <= '0;
            idx_q           <= '0;
            o_rst_stage     <= '1;
            o_ready         <= 1'b0;
            o_pll_stdy_rst  <= 1'b0;
            o_lock_loss_cnt <= '0;
        end else begin
            state_q         <= state_d;
            tmr_q           <= tmr_d;
            idx_q           <= idx_d;
            o_rst_stage     <= stage_d;
            o_ready         <= ready_d;
            o_pll_stdy_rst  <= stdy_d;
            o_lock_loss_cnt <= loss_d;
        end
    end

    assign o_state = state_q;

endmodule

// File: tb/tb_core_rst_seq.sv
// Self-checking bench for core_rst_seq: expected output snapshots are queued with
// their due cycle when stimulus is planned and compared when that cycle arrives.
module tb_core_rst_seq;
    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_pll_locked;
    logic       o_pll_stdy_rst;
    logic [2:0] o_rst_stage;
    logic       o_ready;
    logic [1:0] o_lock_loss_cnt;
    logic [2:0] o_state;

    core_rst_seq #(
        .NUM_STAGES  (3),
        .LOCK_HOLD   (8),
        .STAGE_GAP   (4),
        .STDY_PULSE  (4),
        .LOCK_TIMEOUT(20),
        .CNT_W       (2)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_pll_locked   (i_pll_locked),
        .o_pll_stdy_rst (o_pll_stdy_rst),
        .o_rst_stage    (o_rst_stage),
        .o_ready        (o_ready),
        .o_lock_loss_cnt(o_lock_loss_cnt),
        .o_state        (o_state)
    );

    always #5 i_clk = ~i_clk;

    // Posedge counter: inputs driven at the negedge of cycle c are first sampled at edge c+1.
    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int         cyc;
        logic [9:0] val;
        string      name;
    } exp_t;

    exp_t       sb[$];
    logic [9:0] obs;
    assign obs = {o_state, o_rst_stage, o_ready, o_pll_stdy_rst, o_lock_loss_cnt};

    function automatic void push(int at, logic [2:0] st, logic [2:0] stg, logic rdy,
                                 logic stdy, logic [1:0] cnt, string name);
        exp_t e;
        e.cyc  = at;
        e.val  = {st, stg, rdy, stdy, cnt};
        e.name = name;
        sb.push_back(e);
    endfunction

    task automatic do_reset(input logic lock);
        i_rst        = 1'b1;
        i_pll_locked = lock;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst        = 1'b1;
        i_pll_locked = 1'b0;
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_state !== 3'd0) begin
            errors++; $display("FAIL reset_state got=%0d exp=0", o_state);
        end
        checks++;
        if (o_rst_stage !== 3'b111) begin
            errors++; $display("FAIL reset_stage got=%b exp=111", o_rst_stage);
        end
        checks++;
        if (o_ready !== 1'b0) begin
            errors++; $display("FAIL reset_ready got=%b exp=0", o_ready);
        end
        checks++;
        if (o_pll_stdy_rst !== 1'b0) begin
            errors++; $display("FAIL reset_stdy got=%b exp=0", o_pll_stdy_rst);
        end
        checks++;
        if (o_lock_loss_cnt !== 2'd0) begin
            errors++; $display("FAIL reset_cnt got=%0d exp=0", o_lock_loss_cnt);
        end
    endtask

    task automatic test_release();
        exp_t e;
        int   c;
        do_reset(1'b1);
        c = cyc;
        push(c + 2,  3'd0, 3'b111, 1'b0, 1'b0, 2'd0, "rel_wait");
        push(c + 3,  3'd1, 3'b111, 1'b0, 1'b0, 2'd0, "rel_hold");
        push(c + 11, 3'd2, 3'b111, 1'b0, 1'b0, 2'd0, "rel_enter");
        push(c + 12, 3'd2, 3'b110, 1'b0, 1'b0, 2'd0, "rel_stage0");
        push(c + 15, 3'd2, 3'b110, 1'b0, 1'b0, 2'd0, "rel_gap0");
        push(c + 16, 3'd2, 3'b100, 1'b0, 1'b0, 2'd0, "rel_stage1");
        push(c + 19, 3'd2, 3'b100, 1'b0, 1'b0, 2'd0, "rel_gap1");
        push(c + 20, 3'd2, 3'b000, 1'b0, 1'b0, 2'd0, "rel_stage2");
        push(c + 23, 3'd2, 3'b000, 1'b0, 1'b0, 2'd0, "rel_not_ready");
        push(c + 24, 3'd3, 3'b000, 1'b1, 1'b0, 2'd0, "rel_ready");
        while (sb.size() > 0) begin
            @(negedge i_clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d state/stage/rdy/stdy/cnt got=%b exp=%b", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        exp_t e;
        int   d;
        d = cyc + 1;
        push(d + 2,  3'd3, 3'b000, 1'b1, 1'b0, 2'd0, "loss_pre");
        push(d + 3,  3'd4, 3'b111, 1'b0, 1'b1, 2'd1, "loss_resp");
        push(d + 6,  3'd4, 3'b111, 1'b0, 1'b1, 2'd1, "loss_pulse_last");
        push(d + 7,  3'd0, 3'b111, 1'b0, 1'b0, 2'd1, "loss_pulse_done");
        push(d + 8,  3'd1, 3'b111, 1'b0, 1'b0, 2'd1, "loss_relock");
        push(d + 17, 3'd2, 3'b110, 1'b0, 1'b0, 2'd1, "loss_stage0");
        push(d + 21, 3'd2, 3'b100, 1'b0, 1'b0, 2'd1, "loss_stage1");
        push(d + 25, 3'd2, 3'b000, 1'b0, 1'b0, 2'd1, "loss_stage2");
        push(d + 29, 3'd3, 3'b000, 1'b1, 1'b0, 2'd1, "loss_ready_again");
        while (sb.size() > 0) begin
            @(negedge i_clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d state/stage/rdy/stdy/cnt got=%b exp=%b", e.name, cyc, obs, e.val);
                end
            end
            if (cyc == d)     i_pll_locked = 1'b0;
            if (cyc == d + 4) i_pll_locked = 1'b1;
        end
    endtask

    task automatic test_saturation();
        exp_t       e;
        int         d;
        logic [1:0] cnt;
        for (int i = 0; i < 4; i++) begin
            d   = cyc + 1;
            cnt = (i == 0) ? 2'd2 : 2'd3;
            push(d + 3,  3'd4, 3'b111, 1'b0, 1'b1, cnt, "sat_loss");
            push(d + 7,  3'd0, 3'b111, 1'b0, 1'b0, cnt, "sat_wait");
            push(d + 17, 3'd2, 3'b110, 1'b0, 1'b0, cnt, "sat_release");
            while (sb.size() > 0) begin
                @(negedge i_clk);
                while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                    e = sb.pop_front();
                    checks++;
                    if (obs !== e.val) begin
                        errors++;
                        $display("FAIL %s[%0d] cyc=%0d state/stage/rdy/stdy/cnt got=%b exp=%b", e.name, i, cyc, obs, e.val);
                    end
                end
                if (cyc == d)     i_pll_locked = 1'b0;
                if (cyc == d + 4) i_pll_locked = 1'b1;
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   c;
        do_reset(1'b1);
        c = cyc;
        push(c + 23, 3'd2, 3'b000, 1'b0, 1'b0, 2'd0, "b2b_last_release");
        push(c + 24, 3'd4, 3'b111, 1'b0, 1'b1, 2'd1, "b2b_loss");
        push(c + 25, 3'd4, 3'b111, 1'b0, 1'b1, 2'd1, "b2b_pulse");
        while (sb.size() > 0) begin
            @(negedge i_clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d state/stage/rdy/stdy/cnt got=%b exp=%b", e.name, cyc, obs, e.val);
                end
            end
            if (cyc == c + 21) i_pll_locked = 1'b0;
        end
    endtask

    task automatic test_glitch();
        exp_t e;
        int   c;
        do_reset(1'b1);
        c = cyc;
        push(c + 4,  3'd1, 3'b111, 1'b0, 1'b0, 2'd0, "glitch_hold");
        push(c + 7,  3'd1, 3'b111, 1'b0, 1'b0, 2'd0, "glitch_hold_late");
        push(c + 8,  3'd0, 3'b111, 1'b0, 1'b0, 2'd0, "glitch_back_wait");
        push(c + 9,  3'd1, 3'b111, 1'b0, 1'b0, 2'd0, "glitch_rehold");
        push(c + 16, 3'd1, 3'b111, 1'b0, 1'b0, 2'd0, "glitch_hold_restart");
        push(c + 17, 3'd2, 3'b111, 1'b0, 1'b0, 2'd0, "glitch_release");
        push(c + 18, 3'd2, 3'b110, 1'b0, 1'b0, 2'd0, "glitch_stage0");
        while (sb.size() > 0) begin
            @(negedge i_clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d state/stage/rdy/stdy/cnt got=%b exp=%b", e.name, cyc, obs, e.val);
                end
            end
            if (cyc == c + 5) i_pll_locked = 1'b0;
            if (cyc == c + 6) i_pll_locked = 1'b1;
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   c;
        do_reset(1'b0);
        c = cyc;
        push(c + 19, 3'd0, 3'b111, 1'b0, 1'b0, 2'd0, "to_wait");
        push(c + 20, 3'd4, 3'b111, 1'b0, 1'b1, 2'd0, "to_pulse1");
        push(c + 23, 3'd4, 3'b111, 1'b0, 1'b1, 2'd0, "to_pulse1_last");
        push(c + 24, 3'd0, 3'b111, 1'b0, 1'b0, 2'd0, "to_pulse1_end");
        push(c + 43, 3'd0, 3'b111, 1'b0, 1'b0, 2'd0, "to_wait2");
        push(c + 44, 3'd4, 3'b111, 1'b0, 1'b1, 2'd0, "to_pulse2");
        push(c + 48, 3'd0, 3'b111, 1'b0, 1'b0, 2'd0, "to_pulse2_end");
        while (sb.size() > 0) begin
            @(negedge i_clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d state/stage/rdy/stdy/cnt got=%b exp=%b", e.name, cyc, obs, e.val);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        exp_t e;
        int   c;
        int   b;
        do_reset(1'b1);
        c = cyc;
        b = c + 17;
        push(c + 12, 3'd2, 3'b110, 1'b0, 1'b0, 2'd0, "mid_released");
        push(c + 15, 3'd4, 3'b111, 1'b0, 1'b1, 2'd1, "mid_pulse");
        push(c + 16, 3'd4, 3'b111, 1'b0, 1'b1, 2'd1, "mid_pulse_on");
        push(c + 17, 3'd0, 3'b111, 1'b0, 1'b0, 2'd0, "mid_pulse_reset");
        push(b + 12, 3'd2, 3'b110, 1'b0, 1'b0, 2'd0, "mid_release_again");
        push(b + 14, 3'd0, 3'b111, 1'b0, 1'b0, 2'd0, "mid_release_reset");
        while (sb.size() > 0) begin
            @(negedge i_clk);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                checks++;
                if (obs !== e.val) begin
                    errors++;
                    $display("FAIL %s cyc=%0d state/stage/rdy/stdy/cnt got=%b exp=%b", e.name, cyc, obs, e.val);
                end
            end
            if (cyc == c + 12) i_pll_locked = 1'b0;
            if (cyc == c + 16) begin
                i_rst        = 1'b1;
                i_pll_locked = 1'b1;
            end
            if (cyc == b)      i_rst = 1'b0;
            if (cyc == b + 13) i_rst = 1'b1;
            if (cyc == b + 14) i_rst = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d limit=20000 cycles", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_release();
        test_lock_loss();
        test_saturation();
        test_back_to_back();
        test_glitch();
        test_timeout();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
